// File: rtl/mem_copy_master.sv
// Block-copy bus master for the unified memory port: copies a run of 32-bit words
// from a source to a destination byte address, one read then one write per word.
module mem_copy_master #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic                 i_abort,
    input  logic                 i_mem_gnt,
    input  logic [31:0]          i_Mem_data,
    output logic                 o_mem_req,
    output logic [31:0]          o_Address,
    output logic [31:0]          o_Write_data,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [LEN_WIDTH-1:0] o_words_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]           r_state;
    logic [31:0]          r_src_ptr;
    logic [31:0]          r_dst_ptr;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] r_words_done;
    logic [31:0]          r_buf;
    logic                 r_err;

    logic w_active;
    logic w_rd;
    logic w_wr;
    logic w_bad_start;

    assign w_active    = (r_state == READ) || (r_state == WRITE);
    // Abort gates the strobes in the same cycle, before the state change lands.
    assign w_rd        = (r_state == READ)  && i_mem_gnt && !i_abort;
    assign w_wr        = (r_state == WRITE) && i_mem_gnt && !i_abort;
    assign w_bad_start = (i_len == '0) || (i_src_addr[1:0] != 2'b00) ||
                         (i_dst_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_cnt        <= '0;
            r_words_done <= '0;
            r_buf        <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_src_ptr    <= i_src_addr;
                        r_dst_ptr    <= i_dst_addr;
                        r_cnt        <= i_len;
                        r_words_done <= '0;
                        r_err        <= w_bad_start;
                        r_state      <= w_bad_start ? FINISH : READ;
                    end
                end
                READ: begin
                    if (i_abort) begin
                        r_err   <= 1'b1;
                        r_state <= FINISH;
                    end else if (i_mem_gnt) begin
                        r_buf   <= i_Mem_data;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (i_abort) begin
                        r_err   <= 1'b1;
                        r_state <= FINISH;
                    end else if (i_mem_gnt) begin
                        r_src_ptr    <= r_src_ptr + 32'd4;
                        r_dst_ptr    <= r_dst_ptr + 32'd4;
                        r_cnt        <= r_cnt - 1'b1;
                        r_words_done <= r_words_done + 1'b1;
                        r_state      <= (r_cnt == LEN_WIDTH'(1)) ? FINISH : READ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_Address = 32'd0;
        if (w_rd)
            o_Address = r_src_ptr;
        else if (w_wr)
            o_Address = r_dst_ptr;
    end

    assign o_mem_req    = w_active;
    assign o_busy       = w_active;
    assign o_MemRead    = w_rd;
    assign o_MemWrite   = w_wr;
    assign o_Write_data = r_buf;
    assign o_done       = (r_state == FINISH);
    assign o_err        = r_err;
    assign o_words_done = r_words_done;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: 256-word memory model plus an ascending-order copy
// reference that predicts final memory contents, write sequence and completion time.
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  len;
    logic        abort;
    logic        mem_gnt;
    logic [31:0] Mem_data;
    logic        mem_req;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_done;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [31:0] mem    [256];
    logic [31:0] refmem [256];
    logic        bk_we;
    logic [7:0]  bk_addr;
    logic [31:0] bk_data;

    bit          gpat   [1024];
    logic        rd_log [1024];
    logic        wr_log [1024];
    logic        bz_log [1024];
    logic [31:0] ad_log [1024];
    logic [31:0] wd_log [1024];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          noise_start = 1'b0;

    always #5 clk = ~clk;

    mem_copy_master #(.LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_src_addr(src_addr),
        .i_dst_addr(dst_addr), .i_len(len), .i_abort(abort), .i_mem_gnt(mem_gnt),
        .i_Mem_data(Mem_data), .o_mem_req(mem_req), .o_Address(Address),
        .o_Write_data(Write_data), .o_MemRead(MemRead), .o_MemWrite(MemWrite),
        .o_busy(busy), .o_done(done), .o_err(err), .o_words_done(words_done)
    );

    assign Mem_data = mem[Address[9:2]];

    always @(posedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (MemWrite)
            mem[Address[9:2]] <= Write_data;
    end

    // Bus protocol watch: never both strobes, no stray address, no strobe without grant.
    always @(negedge clk) begin
        if (!reset) begin
            if (MemRead && MemWrite) viol <= viol + 1;
            else if (!MemRead && !MemWrite && Address !== 32'd0) viol <= viol + 1;
            else if ((MemRead || MemWrite) && !mem_gnt) viol <= viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bk_addr = a; bk_data = d; bk_we = 1'b1;
        tick();
        bk_we = 1'b0;
        refmem[a] = d;
    endtask

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [7:0]  sw, dw;
        logic [31:0] v;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < n; i++) begin
            sw = s[9:2] + 8'(i);
            dw = d[9:2] + 8'(i);
            v = refmem[sw];
            refmem[dw] = v;
            exp_a.push_back(d + 32'(4 * i));
            exp_d.push_back(v);
        end
    endtask

    function automatic int exp_done(input int n);
        int c = 0;
        for (int k = 0; k < 1024; k++) begin
            if (gpat[k]) c++;
            if (c == 2 * n) return k + 1;
        end
        return -2;
    endfunction

    function automatic int mem_diff();
        int c = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== refmem[i]) c++;
        return c;
    endfunction

    function automatic bit writes_match(input int nk);
        int j = 0;
        for (int k = 0; k <= nk; k++) begin
            if (wr_log[k]) begin
                if (j >= exp_a.size()) return 1'b0;
                if (ad_log[k] !== exp_a[j] || wd_log[k] !== exp_d[j]) return 1'b0;
                j++;
            end
        end
        return (j == exp_a.size());
    endfunction

    function automatic int strobe_count(input int nk);
        int c = 0;
        for (int k = 0; k <= nk; k++)
            if (rd_log[k] || wr_log[k]) c++;
        return c;
    endfunction

    task automatic gnt_all_one();
        for (int k = 0; k < 1024; k++) gpat[k] = 1'b1;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                            input int abort_at, output int done_k, output logic errv,
                            output logic [7:0] wdn);
        start = 1'b1; src_addr = s; dst_addr = d; len = n; abort = 1'b0; mem_gnt = 1'b1;
        tick();
        start = 1'b0;
        done_k = -1; errv = 1'bx; wdn = 'x;
        for (int k = 0; k < 600; k++) begin
            mem_gnt = gpat[k];
            abort = (k == abort_at);
            if (noise_start) begin
                start = 1'($urandom);
                src_addr = $urandom;
                len = 8'($urandom);
            end
            #1;
            rd_log[k] = MemRead; wr_log[k] = MemWrite; bz_log[k] = busy;
            ad_log[k] = Address; wd_log[k] = Write_data;
            if (done) begin
                done_k = k; errv = err; wdn = words_done;
                start = 1'b0;
                break;
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; mem_gnt = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_req, MemRead, MemWrite, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, MemRead, MemWrite, busy, done, err});
        end
        checks++;
        if (Address !== 32'd0 || Write_data !== 32'd0 || words_done !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h words %0d expected all zero", Address, Write_data, words_done);
        end
    endtask

    task automatic test_basic();
        int dk; logic e; logic [7:0] w;
        for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 32'hA0 + 32'(i));
        gnt_all_one();
        model_copy(32'h80, 32'h100, 4);
        run_copy(32'h80, 32'h100, 8'd4, -1, dk, e, w);
        checks++;
        if (dk !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", dk); end
        checks++;
        if (e !== 1'b0 || w !== 8'd4) begin errors++; $display("FAIL basic_status: err %b words %0d expected 0 4", e, w); end
        checks++;
        if (!(rd_log[0] === 1'b1 && ad_log[0] === 32'h80 && bz_log[0] === 1'b1)) begin
            errors++; $display("FAIL basic_first_read: rd %b addr %h busy %b expected 1 80 1", rd_log[0], ad_log[0], bz_log[0]);
        end
        checks++;
        if (bz_log[8] !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bz_log[8]); end
        checks++;
        if (!writes_match(dk)) begin errors++; $display("FAIL basic_writes: sequence differs from expected 0x100..0x10C / A0..A3"); end
        checks++;
        if (mem_diff() != 0) begin errors++; $display("FAIL basic_mem: %0d words differ, expected 0", mem_diff()); end
    endtask

    task automatic test_stall();
        int dk; logic e; logic [7:0] w;
        gnt_all_one();
        gpat[3] = 1'b0; gpat[4] = 1'b0; gpat[5] = 1'b0;
        model_copy(32'h80, 32'h100, 4);
        run_copy(32'h80, 32'h100, 8'd4, -1, dk, e, w);
        checks++;
        if (dk !== 11) begin errors++; $display("FAIL stall_latency: got %0d expected 11", dk); end
        checks++;
        if ({wr_log[3], wr_log[4], wr_log[5]} !== 3'b000) begin
            errors++; $display("FAIL stall_strobe: got %b expected 000", {wr_log[3], wr_log[4], wr_log[5]});
        end
        checks++;
        if (wd_log[3] !== 32'hA1 || wd_log[4] !== 32'hA1 || wd_log[5] !== 32'hA1) begin
            errors++; $display("FAIL stall_buf: got %h %h %h expected a1", wd_log[3], wd_log[4], wd_log[5]);
        end
        checks++;
        if (!writes_match(dk) || mem_diff() != 0 || e !== 1'b0 || w !== 8'd4) begin
            errors++; $display("FAIL stall_data: err %b words %0d memdiff %0d expected 0 4 0", e, w, mem_diff());
        end
    endtask

    task automatic test_err_start();
        int dk; logic e; logic [7:0] w;
        logic [31:0] ss [3];
        logic [31:0] dd [3];
        logic [7:0]  ll [3];
        ss[0] = 32'h80; dd[0] = 32'h100; ll[0] = 8'd0;
        ss[1] = 32'h82; dd[1] = 32'h100; ll[1] = 8'd3;
        ss[2] = 32'h80; dd[2] = 32'h101; ll[2] = 8'd3;
        gnt_all_one();
        for (int t = 0; t < 3; t++) begin
            run_copy(ss[t], dd[t], ll[t], -1, dk, e, w);
            checks++;
            if (dk !== 0 || e !== 1'b1 || w !== 8'd0 || strobe_count(0) != 0) begin
                errors++;
                $display("FAIL err_start%0d: done_k %0d err %b words %0d strobes %0d expected 0 1 0 0", t, dk, e, w, strobe_count(0));
            end
        end
        checks++;
        if (mem_diff() != 0) begin errors++; $display("FAIL err_start_mem: %0d words differ, expected 0", mem_diff()); end
    endtask

    task automatic test_abort();
        int dk; logic e; logic [7:0] w;
        gnt_all_one();
        model_copy(32'h200, 32'h280, 2);
        run_copy(32'h200, 32'h280, 8'd5, 4, dk, e, w);
        checks++;
        if (dk !== 5 || e !== 1'b1 || w !== 8'd2) begin
            errors++; $display("FAIL abort_status: done_k %0d err %b words %0d expected 5 1 2", dk, e, w);
        end
        checks++;
        if (rd_log[4] !== 1'b0) begin errors++; $display("FAIL abort_gate: MemRead %b expected 0", rd_log[4]); end
        checks++;
        if (!writes_match(dk) || mem_diff() != 0) begin
            errors++; $display("FAIL abort_mem: %0d words differ, expected only 2 destination words written", mem_diff());
        end
    endtask

    task automatic test_overlap();
        int dk; logic e; logic [7:0] w;
        for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 32'(i + 1));
        gnt_all_one();
        model_copy(32'h100, 32'h104, 3);
        run_copy(32'h100, 32'h104, 8'd3, -1, dk, e, w);
        checks++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== {4{32'd1}}) begin
            errors++; $display("FAIL overlap: got %0d %0d %0d %0d expected 1 1 1 1", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
        end
        checks++;
        if (mem_diff() != 0 || dk !== 6 || e !== 1'b0) begin
            errors++; $display("FAIL overlap_misc: memdiff %0d done_k %0d err %b expected 0 6 0", mem_diff(), dk, e);
        end
    endtask

    task automatic test_reset_mid();
        int dk; logic e; logic [7:0] w;
        int seen_done = 0;
        gnt_all_one();
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h380; len = 8'd3; mem_gnt = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #1;
        checks++;
        if (MemWrite !== 1'b1) begin errors++; $display("FAIL rstmid_pre: MemWrite %b expected 1", MemWrite); end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, MemRead, MemWrite, busy, done, err} !== 6'b0 || Address !== 32'd0 ||
            Write_data !== 32'd0 || words_done !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl %b addr %h wdata %h words %0d expected all zero",
                     {mem_req, MemRead, MemWrite, busy, done, err}, Address, Write_data, words_done);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (done) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL rstmid_done: %0d done cycles expected 0", seen_done); end
        model_copy(32'h300, 32'h380, 1);
        checks++;
        if (mem_diff() != 0) begin errors++; $display("FAIL rstmid_mem: %0d words differ, expected 0", mem_diff()); end
        model_copy(32'h300, 32'h380, 1);
        run_copy(32'h300, 32'h380, 8'd1, -1, dk, e, w);
        checks++;
        if (dk !== 2 || e !== 1'b0 || w !== 8'd1 || mem_diff() != 0) begin
            errors++; $display("FAIL rstmid_restart: done_k %0d err %b words %0d memdiff %0d expected 2 0 1 0", dk, e, w, mem_diff());
        end
    endtask

    task automatic test_random();
        int dk, edk; logic e; logic [7:0] w;
        logic [31:0] s, d;
        int n;
        noise_start = 1'b1;
        for (int it = 0; it < 25; it++) begin
            s = {$urandom, 2'b00} ;
            d = {$urandom, 2'b00};
            if (it % 3 == 0) s = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            n = $urandom_range(1, 12);
            for (int k = 0; k < 1024; k++) gpat[k] = ($urandom_range(0, 9) < 7);
            edk = exp_done(n);
            model_copy(s, d, n);
            run_copy(s, d, 8'(n), -1, dk, e, w);
            checks++;
            if (dk !== edk || e !== 1'b0 || w !== 8'(n)) begin
                errors++; $display("FAIL rand%0d_status: done_k %0d err %b words %0d expected %0d 0 %0d", it, dk, e, w, edk, n);
            end
            checks++;
            if (!writes_match(dk) || mem_diff() != 0) begin
                errors++; $display("FAIL rand%0d_data: src %h dst %h len %0d memdiff %0d expected 0", it, s, d, n, mem_diff());
            end
        end
        noise_start = 1'b0;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bus_protocol: %0d violating cycles expected 0", viol); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        abort = 1'b0; mem_gnt = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        repeat (3) tick();
        test_reset();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        test_basic();
        test_stall();
        test_err_start();
        test_abort();
        test_overlap();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
